// File: rtl/mesi_line_ctrl_if.sv
// mesi_line_ctrl_if
//   Groups the three handshakes of the MESI line controller:
//     cpu_*  processor request (valid/ready) and completion pulse
//     bus_*  outgoing bus transaction (req/gnt) plus sharer indication
//     snp_*  snooped command from other caches and registered response
//   slave  : controller view
//   master : environment view (processor, bus arbiter, snoop source)
interface mesi_line_ctrl_if #(
    parameter int IDX_W = 3
) ();
    logic             cpu_valid;
    logic [1:0]       cpu_op;
    logic [IDX_W-1:0] cpu_idx;
    logic             cpu_ready;
    logic             cpu_done;

    logic             bus_req;
    logic [1:0]       bus_cmd;
    logic [IDX_W-1:0] bus_idx;
    logic             bus_gnt;
    logic             bus_share;

    logic             snp_valid;
    logic [1:0]       snp_cmd;
    logic [IDX_W-1:0] snp_idx;
    logic             snp_share;
    logic             snp_flush;

    modport slave (
        input  cpu_valid, cpu_op, cpu_idx, bus_gnt, bus_share,
               snp_valid, snp_cmd, snp_idx,
        output cpu_ready, cpu_done, bus_req, bus_cmd, bus_idx,
               snp_share, snp_flush
    );

    modport master (
        output cpu_valid, cpu_op, cpu_idx, bus_gnt, bus_share,
               snp_valid, snp_cmd, snp_idx,
        input  cpu_ready, cpu_done, bus_req, bus_cmd, bus_idx,
               snp_share, snp_flush
    );
endinterface

// File: rtl/mesi_line_ctrl.sv
// mesi_line_ctrl
//   MESI coherence controller for NUM_LINES cache lines. Processor
//   read/write/evict requests either complete silently or issue a bus
//   transaction (GETS/GETX/INV/PUTX) and wait for the grant. Snooped
//   commands update their line every cycle, including races against the
//   pending transaction.
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   io         controller side of mesi_line_ctrl_if (cpu/bus/snoop)
//   dbg_idx    combinational line-state read address
//   dbg_state  state of line dbg_idx (0=I 1=S 2=E 3=M)
module mesi_line_ctrl #(
    parameter int NUM_LINES = 8,
    parameter int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic             clk,
    input  logic             reset,
    mesi_line_ctrl_if.slave  io,
    input  logic [IDX_W-1:0] dbg_idx,
    output logic [1:0]       dbg_state
);
    typedef enum logic [1:0] {
        INVALID   = 2'd0,
        SHARED    = 2'd1,
        EXCLUSIVE = 2'd2,
        MODIFIED  = 2'd3
    } cache_state_t;

    typedef enum logic [1:0] {
        CMD_GETS = 2'd0,
        CMD_GETX = 2'd1,
        CMD_INV  = 2'd2,
        CMD_PUTX = 2'd3
    } bus_cmd_t;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_EVICT = 2'd2,
        OP_ILL   = 2'd3
    } cpu_op_t;

    typedef enum logic {
        IDLE,
        BUS_WAIT
    } fsm_t;

    fsm_t             fsm;
    cache_state_t     lines     [NUM_LINES];
    cache_state_t     snp_lines [NUM_LINES];
    bus_cmd_t         bus_cmd_q;
    logic             bus_req_q;
    logic [IDX_W-1:0] bus_idx_q;
    logic             cpu_done_q;
    logic             snp_share_q;
    logic             snp_flush_q;

    logic             snp_share_d;
    logic             snp_flush_d;
    logic             snp_on_pending;
    logic             race_inv;
    logic             race_putx;
    cache_state_t     cpu_cur;
    cache_state_t     cpu_new;
    logic             cpu_issue;
    bus_cmd_t         cpu_cmd;

    // Post-snoop view of every line; the CPU decision below reads this so a
    // same-cycle snoop on the requested index is already applied.
    always_comb begin
        for (int unsigned i = 0; i < NUM_LINES; i++) begin
            snp_lines[i] = lines[i];
        end
        snp_share_d = 1'b0;
        snp_flush_d = 1'b0;
        if (io.snp_valid && io.snp_cmd != CMD_PUTX) begin
            snp_share_d = (lines[io.snp_idx] != INVALID);
            snp_flush_d = (lines[io.snp_idx] == MODIFIED) && (io.snp_cmd != CMD_INV);
            if (io.snp_cmd == CMD_GETS) begin
                if (lines[io.snp_idx] != INVALID) begin
                    snp_lines[io.snp_idx] = SHARED;
                end
            end else begin
                snp_lines[io.snp_idx] = INVALID;
            end
        end
    end

    assign snp_on_pending = (fsm == BUS_WAIT) && io.snp_valid && (io.snp_idx == bus_idx_q);
    assign race_inv  = snp_on_pending && (bus_cmd_q == CMD_INV) &&
                       (io.snp_cmd == CMD_GETX || io.snp_cmd == CMD_INV);
    assign race_putx = snp_on_pending && (bus_cmd_q == CMD_PUTX) &&
                       (io.snp_cmd == CMD_GETS || io.snp_cmd == CMD_GETX);

    assign cpu_cur = snp_lines[io.cpu_idx];

    // Either a silent new state for the line or a bus command to issue.
    always_comb begin
        cpu_new   = cpu_cur;
        cpu_issue = 1'b0;
        cpu_cmd   = CMD_GETS;
        case (io.cpu_op)
            OP_WRITE: begin
                case (cpu_cur)
                    MODIFIED, EXCLUSIVE: cpu_new = MODIFIED;
                    SHARED: begin
                        cpu_issue = 1'b1;
                        cpu_cmd   = CMD_INV;
                    end
                    default: begin
                        cpu_issue = 1'b1;
                        cpu_cmd   = CMD_GETX;
                    end
                endcase
            end
            OP_EVICT: begin
                if (cpu_cur == MODIFIED) begin
                    cpu_issue = 1'b1;
                    cpu_cmd   = CMD_PUTX;
                end else begin
                    cpu_new = INVALID;
                end
            end
            default: begin
                if (cpu_cur == INVALID) begin
                    cpu_issue = 1'b1;
                    cpu_cmd   = CMD_GETS;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm <= IDLE;
            for (int unsigned i = 0; i < NUM_LINES; i++) begin
                lines[i] <= INVALID;
            end
            bus_req_q   <= 1'b0;
            bus_cmd_q   <= CMD_GETS;
            bus_idx_q   <= '0;
            cpu_done_q  <= 1'b0;
            snp_share_q <= 1'b0;
            snp_flush_q <= 1'b0;
        end else begin
            // Snoop result first; CPU/bus updates below override the same line.
            for (int unsigned i = 0; i < NUM_LINES; i++) begin
                lines[i] <= snp_lines[i];
            end
            snp_share_q <= snp_share_d;
            snp_flush_q <= snp_flush_d;
            cpu_done_q  <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (io.cpu_valid) begin
                        if (cpu_issue) begin
                            fsm       <= BUS_WAIT;
                            bus_req_q <= 1'b1;
                            bus_cmd_q <= cpu_cmd;
                            bus_idx_q <= io.cpu_idx;
                        end else begin
                            lines[io.cpu_idx] <= cpu_new;
                            cpu_done_q        <= 1'b1;
                        end
                    end
                end
                default: begin
                    // Race snoops take priority and mask a same-cycle grant.
                    if (race_putx) begin
                        lines[bus_idx_q] <= INVALID;
                        bus_req_q        <= 1'b0;
                        cpu_done_q       <= 1'b1;
                        fsm              <= IDLE;
                    end else if (race_inv) begin
                        bus_cmd_q <= CMD_GETX;
                    end else if (io.bus_gnt) begin
                        case (bus_cmd_q)
                            CMD_GETS: lines[bus_idx_q] <= io.bus_share ? SHARED : EXCLUSIVE;
                            CMD_PUTX: lines[bus_idx_q] <= INVALID;
                            default:  lines[bus_idx_q] <= MODIFIED;
                        endcase
                        bus_req_q  <= 1'b0;
                        cpu_done_q <= 1'b1;
                        fsm        <= IDLE;
                    end
                end
            endcase
        end
    end

    assign io.cpu_ready  = (fsm == IDLE);
    assign io.cpu_done   = cpu_done_q;
    assign io.bus_req    = bus_req_q;
    assign io.bus_cmd    = bus_cmd_q;
    assign io.bus_idx    = bus_idx_q;
    assign io.snp_share  = snp_share_q;
    assign io.snp_flush  = snp_flush_q;
    assign dbg_state     = lines[dbg_idx];
endmodule

// File: doc/mesi_line_ctrl.md
# mesi_line_ctrl

Parametrised MESI coherence controller for a cache of NUM_LINES lines, each holding a CacheState (INVALID=0, SHARED=1, EXCLUSIVE=2, MODIFIED=3, from cacheLinePackage).
- Accepts processor read/write/evict requests through a valid/ready handshake.
- Issues bus transactions through a req/gnt handshake.
- Applies snooped bus commands to every line concurrently, including races against its own pending transaction.
- Sits between the cache datapath and the shared snooping bus; supersedes the single-line MESI transition block.

## Interface
- NUM_LINES, default 8: number of tracked lines, ≥2.
- IDX_W, default $clog2(NUM_LINES): line index width.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state.
- cpu_valid  in  1  processor request present.
- cpu_op  in  2  0=READ, 1=WRITE, 2=EVICT; 3 is illegal and treated as READ.
- cpu_idx  in  IDX_W  target line.
- cpu_ready  out  1  high in IDLE; a request is accepted when cpu_valid && cpu_ready.
- cpu_done  out  1  one-cycle pulse when the accepted request completes.
- bus_req  out  1  bus transaction request.
- bus_cmd  out  2  0=GETS, 1=GETX, 2=INV, 3=PUTX.
- bus_idx  out  IDX_W  line of the transaction.
- bus_gnt  in  1  bus grant; completes the transaction in the cycle it is sampled.
- bus_share  in  1  another cache holds the line; sampled with bus_gnt for GETS.
- snp_valid  in  1  snooped command from another cache.
- snp_cmd  in  2  same encoding as bus_cmd; PUTX is ignored.
- snp_idx  in  IDX_W  snooped line.
- snp_share  out  1  registered; the snooped line was non-INVALID.
- snp_flush  out  1  registered; the snooped line was MODIFIED and the command was GETS or GETX, so this cache supplies data.
- dbg_idx  in  IDX_W  combinational state read address.
- dbg_state  out  2  state of line dbg_idx.

## Operation
- FSM has two states, IDLE and BUS_WAIT. cpu_ready = (FSM == IDLE).
- The snoop update is applied before the CPU decision in the same cycle. A CPU decision on the same index sees the post-snoop state.
- Snoop transitions, applied to line snp_idx:
  - GETS: M→S with flush; E→S; S and I unchanged.
  - GETX: M→I with flush; E/S→I.
  - INV: any state→I, no flush.
- Accepted request in IDLE, using the current state of cpu_idx:
  - READ hit (S/E/M): no change; done.
  - READ miss (I): issue GETS; go to BUS_WAIT.
  - WRITE M: done. WRITE E: →M silently; done.
  - WRITE S: issue INV; go to BUS_WAIT. WRITE I: issue GETX; go to BUS_WAIT.
  - EVICT M: issue PUTX; go to BUS_WAIT. EVICT S/E: →I; done. EVICT I: no-op; done.
- BUS_WAIT behaviour:
  - bus_req stays high; bus_cmd and bus_idx stay stable until bus_gnt.
  - On bus_gnt: GETS gives S if bus_share else E; GETX or INV gives M; PUTX gives I. Then bus_req drops, FSM returns to IDLE, and done fires.
- Race rules while in BUS_WAIT, when a snoop (GETX, INV, or GETS on a pending PUTX) hits bus_idx:
  - Pending INV invalidated by snoop GETX or INV: bus_cmd becomes GETX from the next cycle and bus_req stays high.
  - Pending PUTX hit by snoop GETS or GETX: the snoop is applied with flush, then the line is forced to I. bus_req drops next cycle, FSM returns to IDLE, done fires.
  - Any bus_gnt sampled in the same cycle as such a snoop is ignored.
- Snoops to other indices never disturb the pending transaction.

## Timing
- Reset values: all lines INVALID; FSM IDLE.
  - cpu_ready=1, cpu_done=0, bus_req=0, bus_cmd=0, bus_idx=0, snp_share=0, snp_flush=0.
- Silent completion: cpu_done pulses the cycle after accept, and cpu_ready stays high.
- Bus completion: bus_req rises the cycle after accept. cpu_done pulses the cycle after bus_gnt is sampled, and cpu_ready is high in that same cycle.
- Line state changes are visible on dbg_state the cycle after the deciding edge.
- snp_share and snp_flush are valid exactly one cycle after snp_valid, and 0 otherwise.
- Back-to-back snoops are processed one per cycle, with no stall.
- Reset mid-transaction: bus_req drops immediately (asynchronously) and no cpu_done is issued.

## Test plan
- Reset → dbg_state=0 for all idx. READ idx 3 with bus_share=0 → GETS on idx 3. gnt → state 2, cpu_done 1 cycle later.
- Line 3=E, WRITE idx 3 → no bus_req, state 3, cpu_done next cycle. Snoop GETS idx 3 → state 1, snp_flush=1, snp_share=1 next cycle.
- Line 5=S, WRITE idx 5 → INV pending. Snoop GETX idx 5 before gnt → state 0 and bus_cmd=1. gnt → state 3.
- Line 2=M, EVICT idx 2 → PUTX. Snoop GETX idx 2 → snp_flush=1, bus_req drops, state 0, cpu_done pulses with no gnt.
- Pending GETS on idx 1 while snoop GETX hits idx 6 (M) → idx 6 goes to I with flush. gnt with bus_share=1 → idx 1 state 1.
- reset low while BUS_WAIT → bus_req=0 at once, all lines 0, cpu_ready=1.
